rs_issue_select: RTL and testbench
==================================

# rs_issue_select

Issue/select unit at the read side of a reservation-station bank. Each cycle it scans the stations' valid/ready state and picks one entry whose operands are both ready, using round-robin priority. It copies that entry into a one-deep output buffer, then clears the entry through the station's clear/selection port. The buffered instruction is then presented to a functional unit over a valid/ready handshake, with back-to-back issue supported.

## Interface
Parameters:
- REG_FILE_ADDR_WIDTH, 7, physical register tag width
- REG_STATIONS_WIDTH, 2, log2 of station count; N = 2**REG_STATIONS_WIDTH

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- stn_valid  in  N  per-station valid
- stn_rs1_ready  in  N  per-station rs1 ready
- stn_rs2_ready  in  N  per-station rs2 ready
- stn_instr  in  N*32  instruction words, station i at bits [32i+31:32i]
- stn_rd, stn_rs1, stn_rs2  in  N*REG_FILE_ADDR_WIDTH each  tags, same packing
- stn_write_en  in  1  allocator writing a station this cycle (it owns the shared selection port)
- flush  in  1  discard buffered op
- clear  out  1  clear the selected station at the next edge
- reg_stat_selection  out  REG_STATIONS_WIDTH  index being cleared; valid only when clear=1
- issue_valid  out  1  output buffer holds an op
- issue_ready  in  1  functional unit accepts
- issue_instr  out  32;  issue_rd, issue_rs1, issue_rs2  out  REG_FILE_ADDR_WIDTH  buffered op fields
- issue_index  out  REG_STATIONS_WIDTH  source station of buffered op

## Operation
- eligible[i] = stn_valid[i] & stn_rs1_ready[i] & stn_rs2_ready[i]. Only registered station state is used; a CDB broadcast in cycle t can make an entry eligible no earlier than t+1.
- Selection: first eligible index searching rr_ptr, rr_ptr+1, … modulo N (wrap-around).
- buf_free = ~issue_valid | issue_ready.
- load = any_eligible & buf_free & ~stn_write_en & ~flush & ~reset.
- clear = load. reg_stat_selection is the selected index, combinational in the same cycle. When clear=0, reg_stat_selection is driven to 0.
- On load: the buffer captures the selected entry's instr/rd/rs1/rs2/index, issue_valid <= 1, and rr_ptr <= selected+1 mod N.
- Handshake: a transfer occurs on any edge where issue_valid & issue_ready.
  - Transfer without load: issue_valid <= 0.
  - Transfer with load: the new op replaces the old one and issue_valid stays 1, giving one issue per cycle.
- While issue_valid & ~issue_ready, all issue_* outputs are held stable and clear=0.
- stn_write_en=1 inhibits load for that cycle because the selection port is shared. rr_ptr is unchanged and eligibility is re-evaluated next cycle.
- flush: issue_valid <= 0 at the edge and clear=0 that cycle. The op is dropped, its station was already cleared, and rr_ptr is unchanged.
- reset: issue_valid=0, rr_ptr=0, buffer fields=0, clear=0, reg_stat_selection=0. Reset asserted mid-handshake drops the op.

## Timing
- Select-to-issue latency: entry eligible in cycle t with buffer free → clear=1 in t → issue_valid=1 in t+1.
- The station deasserts valid at edge t+1, so the same entry cannot be selected twice.
- Sustained throughput: 1 op/cycle with issue_ready held at 1 and eligible entries available.
- clear and reg_stat_selection are combinational from registered inputs and state. There is no path from issue_ready to issue_* outputs other than through registers. clear depends on issue_ready combinationally.
- No eligible entries: clear=0 and rr_ptr holds.

## Test plan
- Reset, then stn_valid=4'b0100 with both readies set on station 2, issue_ready=1 → clear=1 and sel=2 in cycle t; issue_valid=1 with station 2's fields in t+1; rr_ptr=3.
- Stations 0,1,3 all eligible with rr_ptr=3 and issue_ready=1 → issue order 3,0,1 on consecutive cycles, with no idle cycles between them.
- Buffer full, issue_ready=0 for 3 cycles, station 1 eligible → clear stays 0 and issue_* stays stable. On the cycle issue_ready=1, clear=1 with sel=1, and the next cycle shows station 1's op.
- Station 0 eligible with stn_write_en=1 for one cycle → clear=0 that cycle; clear=1 with sel=0 the following cycle.
- Station 2 has rs1_ready=1 and rs2_ready=0; rs2_ready rises at edge t → clear=1 with sel=2 in cycle t, not earlier.
- Buffered op pending with issue_ready=0; flush=1 → issue_valid=0 next cycle and clear=0 during flush. Reset asserted mid-stream → all outputs at their reset values next cycle.

Source files
------------

// File: rtl/rs_issue_select.sv
// Issue/select stage for a reservation-station bank: round-robin pick of a
// ready entry into a one-deep output buffer with a valid/ready issue port.
module rs_issue_select #(
   parameter int REG_FILE_ADDR_WIDTH = 7,
   parameter int REG_STATIONS_WIDTH  = 2
) (
   input  logic                                                clock,
   input  logic                                                reset,
   input  logic [(2**REG_STATIONS_WIDTH)-1:0]                  stn_valid,
   input  logic [(2**REG_STATIONS_WIDTH)-1:0]                  stn_rs1_ready,
   input  logic [(2**REG_STATIONS_WIDTH)-1:0]                  stn_rs2_ready,
   input  logic [(2**REG_STATIONS_WIDTH)*32-1:0]               stn_instr,
   input  logic [(2**REG_STATIONS_WIDTH)*REG_FILE_ADDR_WIDTH-1:0] stn_rd,
   input  logic [(2**REG_STATIONS_WIDTH)*REG_FILE_ADDR_WIDTH-1:0] stn_rs1,
   input  logic [(2**REG_STATIONS_WIDTH)*REG_FILE_ADDR_WIDTH-1:0] stn_rs2,
   input  logic                                                stn_write_en,
   input  logic                                                flush,
   output logic                                                clear,
   output logic [REG_STATIONS_WIDTH-1:0]                       reg_stat_selection,
   output logic                                                issue_valid,
   input  logic                                                issue_ready,
   output logic [31:0]                                         issue_instr,
   output logic [REG_FILE_ADDR_WIDTH-1:0]                      issue_rd,
   output logic [REG_FILE_ADDR_WIDTH-1:0]                      issue_rs1,
   output logic [REG_FILE_ADDR_WIDTH-1:0]                      issue_rs2,
   output logic [REG_STATIONS_WIDTH-1:0]                       issue_index
);

   localparam int N  = 2**REG_STATIONS_WIDTH;
   localparam int AW = REG_FILE_ADDR_WIDTH;
   localparam int SW = REG_STATIONS_WIDTH;
   localparam logic [SW-1:0] ONE = SW'(1);

   logic [N-1:0]  w_elig;
   logic [31:0]   w_instr_a [N];
   logic [AW-1:0] w_rd_a    [N];
   logic [AW-1:0] w_rs1_a   [N];
   logic [AW-1:0] w_rs2_a   [N];

   logic [SW-1:0] w_sel;
   logic          w_found;
   logic          w_buf_free;
   logic          w_load;

   logic          r_issue_valid;
   logic [SW-1:0] r_rr_ptr;
   logic [31:0]   r_instr;
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_rs1;
   logic [AW-1:0] r_rs2;
   logic [SW-1:0] r_index;

   assign w_elig = stn_valid & stn_rs1_ready & stn_rs2_ready;

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign w_instr_a[g] = stn_instr[32*g +: 32];
      assign w_rd_a[g]    = stn_rd[AW*g +: AW];
      assign w_rs1_a[g]   = stn_rs1[AW*g +: AW];
      assign w_rs2_a[g]   = stn_rs2[AW*g +: AW];
   end

   // Search starts at the round-robin pointer; the narrow index wraps mod N.
   always_comb begin
      logic [SW-1:0] w_cand;
      w_sel   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < N; k++) begin
         w_cand = r_rr_ptr + SW'(k);
         if (!w_found && w_elig[w_cand]) begin
            w_found = 1'b1;
            w_sel   = w_cand;
         end
      end
   end

   assign w_buf_free = ~r_issue_valid | issue_ready;
   assign w_load     = w_found & w_buf_free & ~stn_write_en & ~flush & ~reset;

   assign clear              = w_load;
   assign reg_stat_selection = w_load ? w_sel : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_issue_valid <= 1'b0;
         r_rr_ptr      <= '0;
         r_instr       <= '0;
         r_rd          <= '0;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_index       <= '0;
      end else if (flush) begin
         r_issue_valid <= 1'b0;
      end else if (w_load) begin
         // A load on a transfer edge replaces the departing op directly.
         r_issue_valid <= 1'b1;
         r_rr_ptr      <= w_sel + ONE;
         r_instr       <= w_instr_a[w_sel];
         r_rd          <= w_rd_a[w_sel];
         r_rs1         <= w_rs1_a[w_sel];
         r_rs2         <= w_rs2_a[w_sel];
         r_index       <= w_sel;
      end else if (r_issue_valid && issue_ready) begin
         r_issue_valid <= 1'b0;
      end
   end

   assign issue_valid = r_issue_valid;
   assign issue_instr = r_instr;
   assign issue_rd    = r_rd;
   assign issue_rs1   = r_rs1;
   assign issue_rs2   = r_rs2;
   assign issue_index = r_index;

endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select: bench-owned station array, behavioural
// issue model checked every cycle, plus directed literal expectations.
module tb_rs_issue_select;

   localparam int AW = 7;
   localparam int SW = 2;
   localparam int N  = 4;

   logic            clock;
   logic            reset;
   logic [N-1:0]    stn_valid;
   logic [N-1:0]    stn_rs1_ready;
   logic [N-1:0]    stn_rs2_ready;
   logic [N*32-1:0] stn_instr;
   logic [N*AW-1:0] stn_rd;
   logic [N*AW-1:0] stn_rs1;
   logic [N*AW-1:0] stn_rs2;
   logic            stn_write_en;
   logic            flush;
   logic            clear;
   logic [SW-1:0]   reg_stat_selection;
   logic            issue_valid;
   logic            issue_ready;
   logic [31:0]     issue_instr;
   logic [AW-1:0]   issue_rd;
   logic [AW-1:0]   issue_rs1;
   logic [AW-1:0]   issue_rs2;
   logic [SW-1:0]   issue_index;

   rs_issue_select #(.REG_FILE_ADDR_WIDTH(AW), .REG_STATIONS_WIDTH(SW)) dut (
      .clock(clock), .reset(reset),
      .stn_valid(stn_valid), .stn_rs1_ready(stn_rs1_ready), .stn_rs2_ready(stn_rs2_ready),
      .stn_instr(stn_instr), .stn_rd(stn_rd), .stn_rs1(stn_rs1), .stn_rs2(stn_rs2),
      .stn_write_en(stn_write_en), .flush(flush),
      .clear(clear), .reg_stat_selection(reg_stat_selection),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_instr(issue_instr), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
      .issue_rs2(issue_rs2), .issue_index(issue_index)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   // Model state (current) and its value after the coming edge.
   bit          m_valid = 0, nx_valid = 0;
   int          m_rr = 0, nx_rr = 0;
   logic [31:0] m_instr = '0, nx_instr = '0;
   logic [AW-1:0] m_rd = '0, m_rs1 = '0, m_rs2 = '0;
   logic [AW-1:0] nx_rd = '0, nx_rs1 = '0, nx_rs2 = '0;
   int          m_idx = 0, nx_idx = 0;
   bit          nx_clr = 0;
   int          nx_sel = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pick the first ready station walking forward from the pointer.
   always @(negedge clock) begin
      bit any;
      int sel;
      bit ld;
      any = 0;
      sel = 0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_rr + k) % N;
         if (!any && stn_valid[j] && stn_rs1_ready[j] && stn_rs2_ready[j]) begin
            any = 1;
            sel = j;
         end
      end
      ld = any && (!m_valid || issue_ready) && !stn_write_en && !flush && !reset;
      if (chk_en) begin
         check("clear", {31'd0, clear}, {31'd0, ld});
         check("sel", {30'd0, reg_stat_selection}, ld ? sel : 0);
         check("issue_valid", {31'd0, issue_valid}, {31'd0, m_valid});
         if (m_valid) begin
            check("issue_instr", issue_instr, m_instr);
            check("issue_rd", {25'd0, issue_rd}, {25'd0, m_rd});
            check("issue_rs1", {25'd0, issue_rs1}, {25'd0, m_rs1});
            check("issue_rs2", {25'd0, issue_rs2}, {25'd0, m_rs2});
            check("issue_index", {30'd0, issue_index}, m_idx);
         end
      end
      nx_valid = m_valid; nx_rr = m_rr; nx_instr = m_instr;
      nx_rd = m_rd; nx_rs1 = m_rs1; nx_rs2 = m_rs2; nx_idx = m_idx;
      nx_clr = ld;
      nx_sel = sel;
      if (reset) begin
         nx_valid = 0; nx_rr = 0; nx_instr = '0; nx_rd = '0;
         nx_rs1 = '0; nx_rs2 = '0; nx_idx = 0;
      end else if (ld) begin
         nx_valid = 1;
         nx_rr    = (sel + 1) % N;
         nx_instr = stn_instr[32*sel +: 32];
         nx_rd    = stn_rd[AW*sel +: AW];
         nx_rs1   = stn_rs1[AW*sel +: AW];
         nx_rs2   = stn_rs2[AW*sel +: AW];
         nx_idx   = sel;
      end else if (flush || issue_ready) begin
         nx_valid = 0;
      end
   end

   // Advance one edge: commit model, retire the cleared station.
   task automatic step();
      bit was_reset;
      was_reset = reset;
      @(posedge clock);
      #1;
      m_valid = nx_valid; m_rr = nx_rr; m_instr = nx_instr;
      m_rd = nx_rd; m_rs1 = nx_rs1; m_rs2 = nx_rs2; m_idx = nx_idx;
      if (nx_clr) stn_valid[nx_sel] = 1'b0;
      if (was_reset) chk_en = 1;
   endtask

   task automatic set_stn(input int i, input logic [31:0] ins, input logic [AW-1:0] rd,
                          input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                          input bit rdy1, input bit rdy2);
      stn_instr[32*i +: 32] = ins;
      stn_rd[AW*i +: AW]    = rd;
      stn_rs1[AW*i +: AW]   = r1;
      stn_rs2[AW*i +: AW]   = r2;
      stn_valid[i]          = 1'b1;
      stn_rs1_ready[i]      = rdy1;
      stn_rs2_ready[i]      = rdy2;
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      check(name, act, exp);
   endtask

   initial begin
      reset = 1; stn_valid = '0; stn_rs1_ready = '0; stn_rs2_ready = '0;
      stn_instr = '0; stn_rd = '0; stn_rs1 = '0; stn_rs2 = '0;
      stn_write_en = 0; flush = 0; issue_ready = 0;
      step();
      @(negedge clock);
      lit("rst_valid", {31'd0, issue_valid}, 32'd0);
      lit("rst_clear", {31'd0, clear}, 32'd0);
      lit("rst_index", {30'd0, issue_index}, 32'd0);
      step();
      reset = 0;

      // single eligible station 2
      set_stn(2, 32'h1234_5602, 7'h12, 7'h22, 7'h32, 1, 1);
      issue_ready = 1;
      @(negedge clock);
      lit("t1_clear", {31'd0, clear}, 32'd1);
      lit("t1_sel", {30'd0, reg_stat_selection}, 32'd2);
      lit("t1_valid_t", {31'd0, issue_valid}, 32'd0);
      step();
      @(negedge clock);
      lit("t1_valid", {31'd0, issue_valid}, 32'd1);
      lit("t1_instr", issue_instr, 32'h1234_5602);
      lit("t1_rd", {25'd0, issue_rd}, 32'h12);
      lit("t1_index", {30'd0, issue_index}, 32'd2);
      lit("t1_clear_after", {31'd0, clear}, 32'd0);
      step();

      // stations 0,1,3 with pointer at 3: order 3,0,1 back to back
      set_stn(0, 32'hAAAA_0000, 7'h01, 7'h02, 7'h03, 1, 1);
      set_stn(1, 32'hAAAA_0001, 7'h11, 7'h12, 7'h13, 1, 1);
      set_stn(3, 32'hAAAA_0003, 7'h31, 7'h32, 7'h33, 1, 1);
      @(negedge clock);
      lit("t2_sel_a", {30'd0, reg_stat_selection}, 32'd3);
      step();
      @(negedge clock);
      lit("t2_sel_b", {30'd0, reg_stat_selection}, 32'd0);
      lit("t2_idx_b", {30'd0, issue_index}, 32'd3);
      step();
      @(negedge clock);
      lit("t2_sel_c", {30'd0, reg_stat_selection}, 32'd1);
      lit("t2_idx_c", {30'd0, issue_index}, 32'd0);
      lit("t2_clear_c", {31'd0, clear}, 32'd1);
      step();
      @(negedge clock);
      lit("t2_idx_d", {30'd0, issue_index}, 32'd1);
      lit("t2_instr_d", issue_instr, 32'hAAAA_0001);
      step();

      // backpressure: station 1 waits while the buffer is stalled
      set_stn(0, 32'hBBBB_0000, 7'h41, 7'h42, 7'h43, 1, 1);
      issue_ready = 0;
      @(negedge clock);
      lit("t3_sel0", {30'd0, reg_stat_selection}, 32'd0);
      step();
      set_stn(1, 32'hBBBB_0001, 7'h51, 7'h52, 7'h53, 1, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         lit("t3_stall_clear", {31'd0, clear}, 32'd0);
         lit("t3_stall_instr", issue_instr, 32'hBBBB_0000);
         step();
      end
      issue_ready = 1;
      @(negedge clock);
      lit("t3_clear", {31'd0, clear}, 32'd1);
      lit("t3_sel1", {30'd0, reg_stat_selection}, 32'd1);
      step();
      @(negedge clock);
      lit("t3_idx", {30'd0, issue_index}, 32'd1);
      step();

      // allocator owns the selection port for a cycle
      set_stn(0, 32'hCCCC_0000, 7'h61, 7'h62, 7'h63, 1, 1);
      stn_write_en = 1;
      @(negedge clock);
      lit("t4_inhibit", {31'd0, clear}, 32'd0);
      step();
      stn_write_en = 0;
      @(negedge clock);
      lit("t4_clear", {31'd0, clear}, 32'd1);
      lit("t4_sel", {30'd0, reg_stat_selection}, 32'd0);
      step();

      // rs2 becomes ready late
      set_stn(2, 32'hDDDD_0002, 7'h71, 7'h72, 7'h73, 1, 0);
      @(negedge clock);
      lit("t5_early", {31'd0, clear}, 32'd0);
      step();
      stn_rs2_ready[2] = 1;
      @(negedge clock);
      lit("t5_clear", {31'd0, clear}, 32'd1);
      lit("t5_sel", {30'd0, reg_stat_selection}, 32'd2);
      step();
      issue_ready = 0;
      @(negedge clock);
      lit("t5_idx", {30'd0, issue_index}, 32'd2);
      step();

      // flush drops the pending op and gates clear
      flush = 1; issue_ready = 1;
      set_stn(3, 32'hEEEE_0003, 7'h01, 7'h05, 7'h09, 1, 1);
      @(negedge clock);
      lit("t6_flush_clear", {31'd0, clear}, 32'd0);
      step();
      flush = 0;
      @(negedge clock);
      lit("t6_valid", {31'd0, issue_valid}, 32'd0);
      lit("t6_sel", {30'd0, reg_stat_selection}, 32'd3);
      step();
      @(negedge clock);
      lit("t6_idx", {30'd0, issue_index}, 32'd3);
      step();

      // reset during a stalled handshake
      issue_ready = 0;
      set_stn(0, 32'hFFFF_0000, 7'h0A, 7'h0B, 7'h0C, 1, 1);
      @(negedge clock);
      lit("t7_sel", {30'd0, reg_stat_selection}, 32'd0);
      step();
      reset = 1;
      @(negedge clock);
      lit("t7_rst_clear", {31'd0, clear}, 32'd0);
      step();
      @(negedge clock);
      lit("t7_valid", {31'd0, issue_valid}, 32'd0);
      lit("t7_instr", issue_instr, 32'd0);
      lit("t7_rd", {25'd0, issue_rd}, 32'd0);
      lit("t7_index", {30'd0, issue_index}, 32'd0);
      step();
      reset = 0;

      // mixed traffic, checked by the model alone
      for (int cyc = 0; cyc < 400; cyc++) begin
         issue_ready  = ($urandom_range(3) != 0);
         stn_write_en = ($urandom_range(4) == 0);
         flush        = ($urandom_range(15) == 0);
         reset        = ($urandom_range(63) == 0);
         for (int i = 0; i < N; i++) begin
            if (!stn_valid[i] && $urandom_range(2) == 0)
               set_stn(i, $urandom, AW'($urandom), AW'($urandom), AW'($urandom),
                       $urandom_range(1) == 1, $urandom_range(1) == 1);
            else if (stn_valid[i]) begin
               if ($urandom_range(2) == 0) stn_rs1_ready[i] = 1;
               if ($urandom_range(2) == 0) stn_rs2_ready[i] = 1;
            end
         end
         step();
      end
      reset = 0; flush = 0; stn_write_en = 0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
